// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game of Life run controller.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PROGRAM = 2'b01,
    RUN     = 2'b10,
    PAUSE   = 2'b11
  } gol_state_e;

  localparam int STATE_W = 2;

  // Button lanes feeding the edge-detector array
  localparam int NUM_BTN = 4;
  localparam int B_PRGM  = 0;
  localparam int B_PP    = 1;
  localparam int B_BTN0  = 2;
  localparam int B_BTN1  = 3;

  // Cursor/counter width that stays >=1 even for a single-entry range
  function automatic int cur_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gol_edge_det.sv
// Rising-edge detector; both flops reset high so a level held through reset never pulses.
module gol_edge_det (
  input  logic clka,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic smp, dly;

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      smp <= 1'b1;
      dly <= 1'b1;
    end else begin
      smp <= din;
      dly <= smp;
    end
  end

  assign pulse = smp & ~dly;

endmodule

// File: rtl/gol_run_ctrl.sv
// IDLE/PROGRAM/RUN/PAUSE run controller: edit cursor, toggle strobe, generation tick.
// Define GOL_STEP_EN to let a btn0 edge in PAUSE issue a single generation step.
module gol_run_ctrl
  import gol_pkg::*;
#(
  parameter int GRID_W   = 8,
  parameter int GRID_H   = 8,
  parameter int TICK_DIV = 1000000,
  parameter int GEN_W    = 16
) (
  input  logic                       clka,
  input  logic                       rst_n,
  input  logic                       stop,
  input  logic                       prgm,
  input  logic                       pp,
  input  logic                       btn0,
  input  logic                       btn1,
  output logic [STATE_W-1:0]         game_state,
  output logic                       gen_tick,
  output logic                       cell_we,
  output logic [cur_w(GRID_W)-1:0]   cell_x,
  output logic [cur_w(GRID_H)-1:0]   cell_y,
  output logic [GEN_W-1:0]           gen_count
);

  localparam int X_W   = cur_w(GRID_W);
  localparam int Y_W   = cur_w(GRID_H);
  localparam int CNT_W = cur_w(TICK_DIV);
  localparam logic [X_W-1:0]   X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [NUM_BTN-1:0] btn_lvl, btn_edge;
  logic               stop_q;

  assign btn_lvl = {btn1, btn0, pp, prgm};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
    gol_edge_det u_edge (
      .clka  (clka),
      .rst_n (rst_n),
      .din   (btn_lvl[i]),
      .pulse (btn_edge[i])
    );
  end

  always_ff @(posedge clka) begin
    if (!rst_n) stop_q <= 1'b0;
    else        stop_q <= stop;
  end

  gol_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [GEN_W-1:0] gc_nxt;
  logic             tick_nxt, we_nxt;
  logic [X_W-1:0]   x_nxt, adv_x;
  logic [Y_W-1:0]   y_nxt, adv_y;
  // Cursor advance deferred one cycle when it collides with a write strobe
  logic             pend, pend_nxt;

  always_comb begin
    adv_x = cell_x + 1'b1;
    adv_y = cell_y;
    if (cell_x == X_MAX) begin
      adv_x = '0;
      adv_y = (cell_y == Y_MAX) ? '0 : cell_y + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gc_nxt    = gen_count;
    tick_nxt  = 1'b0;
    we_nxt    = 1'b0;
    x_nxt     = cell_x;
    y_nxt     = cell_y;
    pend_nxt  = 1'b0;
    if (pend) begin
      x_nxt = adv_x;
      y_nxt = adv_y;
    end
    if (stop_q) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      gc_nxt    = '0;
      x_nxt     = '0;
      y_nxt     = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (btn_edge[B_PRGM]) begin
            state_nxt = PROGRAM;
            x_nxt     = '0;
            y_nxt     = '0;
          end
        end
        PROGRAM: begin
          we_nxt = btn_edge[B_BTN1];
          if (btn_edge[B_BTN0]) begin
            if (btn_edge[B_BTN1]) pend_nxt = 1'b1;
            else begin
              x_nxt = adv_x;
              y_nxt = adv_y;
            end
          end
          // Fresh RUN always starts a full tick period
          if (btn_edge[B_PP]) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        RUN: begin
          if (cnt == CNT_MAX) begin
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            gc_nxt   = gen_count + 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
          if (btn_edge[B_PP]) state_nxt = PAUSE;
        end
        PAUSE: begin
          if (btn_edge[B_PRGM]) begin
            state_nxt = PROGRAM;
            x_nxt     = '0;
            y_nxt     = '0;
          end else if (btn_edge[B_PP]) begin
            state_nxt = RUN;
          end
`ifdef GOL_STEP_EN
          if (btn_edge[B_BTN0]) begin
            tick_nxt = 1'b1;
            gc_nxt   = gen_count + 1'b1;
          end
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gen_count <= '0;
      gen_tick  <= 1'b0;
      cell_we   <= 1'b0;
      cell_x    <= '0;
      cell_y    <= '0;
      pend      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gen_count <= gc_nxt;
      gen_tick  <= tick_nxt;
      cell_we   <= we_nxt;
      cell_x    <= x_nxt;
      cell_y    <= y_nxt;
      pend      <= pend_nxt;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_gol_run_ctrl.sv
// Directed bench for gol_run_ctrl on a 4x4 grid with TICK_DIV=4.
module tb_gol_run_ctrl;

  logic        clka = 1'b0;
  logic        rst_n, stop, prgm, pp, btn0, btn1;
  logic [1:0]  game_state;
  logic        gen_tick, cell_we;
  logic [1:0]  cell_x, cell_y;
  logic [15:0] gen_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clka = ~clka;

  gol_run_ctrl #(.GRID_W(4), .GRID_H(4), .TICK_DIV(4), .GEN_W(16)) dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .stop       (stop),
    .prgm       (prgm),
    .pp         (pp),
    .btn0       (btn0),
    .btn1       (btn1),
    .game_state (game_state),
    .gen_tick   (gen_tick),
    .cell_we    (cell_we),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .gen_count  (gen_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  // Raise btn0 for two edges (effect now visible), release, then one idle edge
  task automatic adv(input int n);
    repeat (n) begin
      btn0 = 1'b1; step(2); btn0 = 1'b0; step(1);
    end
  endtask

  int ticks;

  initial begin
    rst_n = 1'b0; stop = 1'b0; prgm = 1'b0; pp = 1'b1; btn0 = 1'b0; btn1 = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(3);
    chk("rst_state", game_state, 0);
    chk("rst_tick",  gen_tick,   0);
    chk("rst_we",    cell_we,    0);
    chk("rst_xy",    {cell_x, cell_y}, 0);
    chk("rst_gc",    gen_count,  0);
    pp = 1'b0; step(2);
    chk("pp_held_no_edge", game_state, 0);

    // IDLE -> PROGRAM with two-edge latency
    prgm = 1'b1; step(1);
    chk("prgm_lat1", game_state, 0);
    step(1);
    chk("prgm_lat2", game_state, 1);
    prgm = 1'b0; step(1);

    adv(5);
    chk("cur5_x", cell_x, 1);
    chk("cur5_y", cell_y, 1);
    btn1 = 1'b1; step(2); btn1 = 1'b0;
    chk("we_pulse", cell_we, 1);
    chk("we_xy", {cell_x, cell_y}, 4'b0101);
    step(1);
    chk("we_one_cycle", cell_we, 0);

    adv(11);
    chk("wrap16", {cell_x, cell_y}, 0);
    adv(15);
    chk("cur15", {cell_x, cell_y}, 4'b1111);
    adv(1);
    chk("cur16_wrap", {cell_x, cell_y}, 0);
    adv(15);
    btn0 = 1'b1; btn1 = 1'b1; step(2); btn0 = 1'b0; btn1 = 1'b0;
    chk("dual_we", cell_we, 1);
    chk("dual_old_xy", {cell_x, cell_y}, 4'b1111);
    step(1);
    chk("dual_we_off", cell_we, 0);
    chk("dual_adv_xy", {cell_x, cell_y}, 0);

    // RUN: tick every 4 cycles
    pp = 1'b1; step(2); pp = 1'b0;
    chk("run_state", game_state, 2);
    step(3);
    chk("tick_early", gen_tick, 0);
    step(1);
    chk("tick1", gen_tick, 1);
    chk("gc1", gen_count, 1);
    step(1);
    chk("tick1_off", gen_tick, 0);
    step(3);
    chk("tick2", gen_tick, 1);
    step(4);
    chk("tick3", gen_tick, 1);
    chk("gc3", gen_count, 3);

    // PAUSE holds counter at 2
    pp = 1'b1; step(2); pp = 1'b0;
    chk("pause_state", game_state, 3);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (gen_tick) ticks++;
    end
    chk("pause_no_tick", ticks, 0);
    chk("pause_gc", gen_count, 3);

    pp = 1'b1; step(2); pp = 1'b0;
    chk("resume_state", game_state, 2);
    chk("resume_tick0", gen_tick, 0);
    step(1);
    chk("resume_tick_wait", gen_tick, 0);
    step(1);
    chk("resume_tick", gen_tick, 1);
    chk("gc4", gen_count, 4);

    // Pause again (counter 2) and try a single step
    pp = 1'b1; step(2); pp = 1'b0;
    chk("pause2_state", game_state, 3);
    step(1);
    btn0 = 1'b1; step(2); btn0 = 1'b0;
`ifdef GOL_STEP_EN
    chk("step_tick", gen_tick, 1);
    chk("step_gc", gen_count, 5);
`else
    chk("step_tick", gen_tick, 0);
    chk("step_gc", gen_count, 4);
`endif
    chk("step_state", game_state, 3);
    step(1);
    chk("step_tick_off", gen_tick, 0);

    // Resume with counter 2; stop swallows the tick that would follow
    pp = 1'b1; step(2); pp = 1'b0;
    stop = 1'b1;
    step(1);
    chk("stop_lat", game_state, 2);
    step(1);
    chk("stop_state", game_state, 0);
    chk("stop_tick", gen_tick, 0);
    chk("stop_gc", gen_count, 0);
    stop = 1'b0; step(1);
    pp = 1'b1; step(2); pp = 1'b0; step(1);
    chk("idle_pp_ignored", game_state, 0);

    // PAUSE with simultaneous prgm+pp: prgm wins, gen_count kept
    prgm = 1'b1; step(2); prgm = 1'b0; step(1);
    adv(2);
    pp = 1'b1; step(2); pp = 1'b0;
    step(4);
    chk("run2_gc", gen_count, 1);
    pp = 1'b1; step(2); pp = 1'b0;
    chk("pause3_state", game_state, 3);
    step(1);
    prgm = 1'b1; pp = 1'b1; step(2); prgm = 1'b0; pp = 1'b0;
    chk("prgm_wins", game_state, 1);
    chk("prgm_keep_gc", gen_count, 1);
    chk("prgm_cur0", {cell_x, cell_y}, 0);
    step(1);

    // Reset mid-RUN
    pp = 1'b1; step(2); pp = 1'b0;
    step(2);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("rst_mid_state", game_state, 0);
    chk("rst_mid_gc", gen_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gol_run_ctrl.md
# gol_run_ctrl

Parametrised run controller for the Game of Life core. It sequences IDLE/PROGRAM/RUN/PAUSE from debounced front-panel levels on a single clock. In PROGRAM it drives a raster edit cursor and cell-toggle strobes into the grid memory. In RUN it generates the generation-advance tick from a programmable divider and counts generations. It sits between the button debouncers and the grid/update engine.

## Interface
- `GRID_W`, default 8: grid columns; cursor x range 0..GRID_W-1.
- `GRID_H`, default 8: grid rows; cursor y range 0..GRID_H-1.
- `TICK_DIV`, default 1000000: clock cycles per generation in RUN; must be ≥2.
- `GEN_W`, default 16: generation counter width.
- `clka` in 1: sole clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `stop` in 1: level; forces IDLE.
- `prgm` in 1: level; rising edge requests PROGRAM.
- `pp` in 1: level; rising edge is play/pause.
- `btn0` in 1: level; rising edge advances the cursor, or steps one generation (see Configuration).
- `btn1` in 1: level; rising edge toggles the cell under the cursor.
- `game_state` out 2: state encoding IDLE=00, PROGRAM=01, RUN=10, PAUSE=11.
- `gen_tick` out 1: one-cycle generation-advance pulse.
- `cell_we` out 1: one-cycle toggle strobe.
- `cell_x` out $clog2(GRID_W): cursor column.
- `cell_y` out $clog2(GRID_H): cursor row.
- `gen_count` out GEN_W: generations since leaving IDLE; wraps at 2^GEN_W.

## Operation
- **Input registration:** `prgm`, `pp`, `btn0` and `btn1` each pass through a sample flop and a delay flop. Edge pulse = sample & ~delay. Both flops reset to 1, so a button held through reset never produces an edge. `stop` is sampled once and is level-acting.
- **Stop priority:** sampled `stop`=1 overrides everything on the next edge. The block goes to IDLE, clears the cursor, tick counter and `gen_count`, and forces `gen_tick`=`cell_we`=0.
- **IDLE:** `prgm` edge goes to PROGRAM with the cursor at (0,0). All other edges are ignored.
- **PROGRAM:**
  - `btn1` edge pulses `cell_we` with the current (pre-advance) cursor.
  - `btn0` edge advances the cursor in raster order: x+1; at x=GRID_W-1, x=0 and y+1; at the last cell, wrap to (0,0).
  - If `btn0` and `btn1` edges arrive together, the write goes to the old cursor and the cursor then advances.
  - `pp` edge goes to RUN. A write in the same cycle still completes.
- **RUN:**
  - The tick counter counts 0..TICK_DIV-1.
  - At terminal count: counter←0, `gen_tick`←1, `gen_count`←+1.
  - `pp` edge goes to PAUSE with the counter held. If terminal count coincides with the `pp` edge, the tick still fires and PAUSE holds counter 0.
  - `prgm`, `btn0` and `btn1` edges are ignored.
- **PAUSE:**
  - `pp` edge goes to RUN; the counter resumes from its held value.
  - `prgm` edge goes to PROGRAM; the cursor resets to (0,0) and `gen_count` is kept.
  - If `pp` and `prgm` edges arrive together, `prgm` wins.
- **Reset values:** `game_state`=00, `gen_tick`=0, `cell_we`=0, `cell_x`=`cell_y`=0, `gen_count`=0, tick counter 0. Reset asserted mid-RUN behaves identically to power-up.

## Timing
- All outputs are registered.
- An input level that rises before edge k produces a state, cursor or strobe update visible after edge k+1, i.e. 2-cycle latency.
- `stop` sampled at edge k takes effect after edge k+1.
- `gen_tick` period in uninterrupted RUN is exactly TICK_DIV cycles. The first tick follows TICK_DIV cycles after `game_state` shows RUN.
- `gen_count` and `gen_tick` update on the same edge.
- `cell_we`, `cell_x` and `cell_y` are coherent in the strobe cycle.

## Configuration
- `GOL_STEP_EN` defined: in PAUSE, a `btn0` edge issues exactly one `gen_tick` and `gen_count`+1. The state stays PAUSE and the tick counter is untouched.
- `GOL_STEP_EN` undefined: `btn0` is ignored in PAUSE and the step logic is not compiled.

## Structure
- Package `gol_pkg`:
  - state enum (IDLE/PROGRAM/RUN/PAUSE) with the 2-bit encodings above;
  - `game_state` width constant;
  - cursor-width helper functions.
- Sub-module `gol_edge_det`: sample/delay flops plus pulse, with reset value 1. Instantiated once per button input.

## Test plan
- Hold `pp`=1 while `rst_n`=0 for 3 cycles, then release → all outputs 0, `game_state`=00 and no transition while `pp` stays high.
- GRID 4x4: `prgm` edge → `game_state`=01 two edges later; 5 `btn0` edges → (1,1); `btn1` edge → `cell_we`=1 for one cycle with x=1, y=1.
- Cursor wrap: from (0,0), 15 `btn0` edges → (3,3), the 16th → (0,0); simultaneous `btn0`+`btn1` at (3,3) → write to (3,3), cursor then (0,0).
- TICK_DIV=4:
  - `pp` edge → RUN, `gen_tick` every 4 cycles, `gen_count`=3 after 3 ticks;
  - `pp` edge → PAUSE, no tick for 20 cycles, `gen_count` stays 3;
  - `pp` edge → RUN, next tick after the remaining held count.
- `stop` asserted in RUN with counter=2 → IDLE after 2 edges, `gen_count`=0, no `gen_tick` emitted.
- `GOL_STEP_EN` in PAUSE: `btn0` edge → exactly one `gen_tick`, `gen_count` 3→4, state stays 11. Without the macro → no tick.
